l2_cache_ctl_nway: RTL

L2_CACHE_CTL_NWAY -- requirements
Module: l2_cache_ctl_nway

---
 rtl/l2_cache_ctl_nway.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/l2_cache_ctl_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : l2_cache_ctl_nway                                            |
// | Description : N-way set-associative L2 cache controller. Tree-PLRU         |
// |               replacement, write-back/write-allocate. The IDLE/WRITE_BACK/ |
// |               FETCH FSM sequences victim eviction and line refill.          |
// | Option      : define L2_CTL_PERF_CNT_EN to add saturating hit, miss and    |
// |               writeback counters (hit_cnt, miss_cnt, wb_cnt).              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module l2_cache_ctl_nway #(
  parameter int WAYS = 8,
  parameter int WIDX = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            mem_resp,
  input  logic [WAYS-1:0] hit_vec,
  input  logic [WAYS-1:0] valid_vec,
  input  logic [WAYS-1:0] dirty_vec,
  input  logic [WAYS-2:0] plru_in,
  output logic [WAYS-2:0] plru_out,
  output logic            load_plru,
  output logic [WAYS-1:0] load_tag,
  output logic [WAYS-1:0] load_valid,
  output logic [WAYS-1:0] load_dirty,
  output logic            valid_in,
  output logic            dirty_in,
  output logic            pmem_read,
  output logic            pmem_write,
  input  logic            pmem_resp,
  output logic [WIDX-1:0] way_sel,
  output logic            wb_addr_sel,
`ifdef L2_CTL_PERF_CNT_EN
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt,
  output logic [31:0]     wb_cnt,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE_BACK = 2'd1,
    ST_FETCH      = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDX-1:0] r_victim;

  logic            w_req;
  logic            w_hit;
  logic            w_miss;
  logic [WIDX-1:0] w_hit_idx;
  logic [WIDX-1:0] w_inv_idx;
  logic            w_has_inv;
  logic [WIDX-1:0] w_victim;
  logic [WAYS-1:0] w_hit_onehot;
  logic [WAYS-1:0] w_vic_onehot;

  // Walk the heap-ordered tree: a 0 bit means the LRU side is the left child.
  function automatic logic [WIDX-1:0] plru_victim(input logic [WAYS-2:0] p);
    logic [WIDX-1:0] n;
    logic [WIDX-1:0] w;
    logic            b;
    n = '0;
    w = '0;
    for (int l = 0; l < WIDX; l++) begin
      b = p[n];
      w = (w << 1) | WIDX'(b);
      n = (n << 1) + WIDX'(1) + WIDX'(b);
    end
    return w;
  endfunction

  // Point every node on the path to way w away from it; other bits untouched.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p,
                                                 input logic [WIDX-1:0] w);
    logic [WAYS-2:0] r;
    logic [WIDX-1:0] n;
    logic [WIDX-1:0] ws;
    logic            b;
    r  = p;
    n  = '0;
    ws = w;
    for (int l = 0; l < WIDX; l++) begin
      b    = ws[WIDX-1];
      r[n] = ~b;
      n    = (n << 1) + WIDX'(1) + WIDX'(b);
      ws   = ws << 1;
    end
    return r;
  endfunction

  assign w_req = mem_read ^ mem_write;
  assign w_hit = |hit_vec;

  // Lowest-index hit way and lowest-index invalid way (priority encoders).
  always_comb begin
    w_hit_idx = '0;
    w_inv_idx = '0;
    w_has_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        w_hit_idx = WIDX'(i);
      end
      if (!valid_vec[i]) begin
        w_inv_idx = WIDX'(i);
        w_has_inv = 1'b1;
      end
    end
  end

  assign w_victim     = w_has_inv ? w_inv_idx : plru_victim(plru_in);
  assign w_hit_onehot = WAYS'(1) << w_hit_idx;
  assign w_vic_onehot = WAYS'(1) << r_victim;

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Victim is captured at miss entry so later array changes cannot move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_victim <= '0;
    end else if (w_miss) begin
      r_victim <= w_victim;
    end
  end

  // Next-state and output decode; outputs are forced idle while reset is low.
  always_comb begin
    w_state_nxt = r_state;
    w_miss      = 1'b0;
    mem_resp    = 1'b0;
    load_plru   = 1'b0;
    plru_out    = plru_in;
    load_tag    = '0;
    load_valid  = '0;
    load_dirty  = '0;
    valid_in    = 1'b0;
    dirty_in    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    wb_addr_sel = 1'b0;
    way_sel     = r_victim;
    case (r_state)
      ST_IDLE: begin
        way_sel = w_hit ? w_hit_idx : w_victim;
        if (w_req) begin
          if (w_hit) begin
            mem_resp  = 1'b1;
            load_plru = 1'b1;
            plru_out  = plru_touch(plru_in, w_hit_idx);
            if (mem_write) begin
              load_tag   = w_hit_onehot;
              load_dirty = w_hit_onehot;
              valid_in   = 1'b1;
              dirty_in   = 1'b1;
            end
          end else begin
            w_miss      = 1'b1;
            w_state_nxt = (valid_vec[w_victim] && dirty_vec[w_victim]) ?
                          ST_WRITE_BACK : ST_FETCH;
          end
        end
      end
      ST_WRITE_BACK: begin
        pmem_write  = 1'b1;
        wb_addr_sel = 1'b1;
        if (pmem_resp) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        pmem_read  = 1'b1;
        load_tag   = w_vic_onehot;
        load_valid = w_vic_onehot;
        load_dirty = w_vic_onehot;
        valid_in   = 1'b1;
        if (pmem_resp) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (!rst_n) begin
      w_state_nxt = ST_IDLE;
      w_miss      = 1'b0;
      mem_resp    = 1'b0;
      load_plru   = 1'b0;
      plru_out    = plru_in;
      load_tag    = '0;
      load_valid  = '0;
      load_dirty  = '0;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
    end
  end

  assign busy = rst_n && (r_state != ST_IDLE);

`ifdef L2_CTL_PERF_CNT_EN
  // Saturating event counters: hit responses, miss entries, writeback entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (mem_resp && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (w_miss && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
      if (w_miss && (w_state_nxt == ST_WRITE_BACK) && (wb_cnt != '1)) begin
        wb_cnt <= wb_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
